iiitb_gc_updn: RTL and testbench

Parametrised successor to the team's fixed 8-bit Gray counter. Adds WIDTH generalisation, up/down counting, synchronous clear and load (Gray-coded input), wrap or saturate end behaviour, and a terminal-count pulse. Used as a pointer or position source wherever a single-bit-change count is needed, such as CDC pointers and encoder emulation. Registered Gray output and matching binary output.

---
 rtl/iiitb_gc_pkg.sv | 24 ++
 rtl/iiitb_gc_g2b.sv | 19 +
 rtl/iiitb_gc_updn.sv | 103 ++++++++++
 tb/tb_iiitb_gc_updn.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_gc_pkg.sv
// Shared helpers for the up/down Gray counter: code conversions and direction encoding.
package iiitb_gc_pkg;

  localparam logic GC_UP = 1'b1;
  localparam logic GC_DN = 1'b0;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB of a width-bit Gray word down to bit 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
    logic [31:0] b;
    logic        x;
    b = '0;
    x = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      x    = x ^ g[i];
      b[i] = x;
    end
    return b;
  endfunction

endpackage

// File: rtl/iiitb_gc_g2b.sv
// Combinational Gray-to-binary converter (prefix XOR, MSB first) for the load path.
module iiitb_gc_g2b #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    logic [WIDTH-1:0] acc;
    acc = '0;
    acc[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      acc[i] = acc[i+1] ^ gray[i];
    end
    bin = acc;
  end

endmodule

// File: rtl/iiitb_gc_updn.sv
// Parametrised up/down Gray counter with clear, Gray load, wrap/saturate ends and a tc pulse.
// Optional step checker (gc_err output) is built when GC_STEP_CHECK_EN is defined.
module iiitb_gc_updn
  import iiitb_gc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count,
  output logic             tc
`ifdef GC_STEP_CHECK_EN
  ,
  output logic             gc_err
`endif
);

  localparam logic [WIDTH-1:0] RV      = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RV_GRAY = RV ^ (RV >> 1);
  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] nb;
  logic             ntc;
  logic             at_max;
  logic             at_min;

  iiitb_gc_g2b #(.WIDTH(WIDTH)) u_g2b (
    .gray (load_gray),
    .bin  (load_bin)
  );

  assign at_max = (bin_count == MAX);
  assign at_min = (bin_count == '0);

  // tc flags the wrap step in wrap mode, and the step that reaches the limit in saturate mode.
  always_comb begin
    nb  = bin_count;
    ntc = 1'b0;
    if (clear) begin
      nb = RV;
    end else if (load) begin
      nb = load_bin;
    end else if (enable) begin
      if (up_dn == GC_UP) begin
        if (!(SAT && at_max)) begin
          nb  = bin_count + ONE;
          ntc = SAT ? (bin_count == MAX - ONE) : at_max;
        end
      end else begin
        if (!(SAT && at_min)) begin
          nb  = bin_count - ONE;
          ntc = SAT ? (bin_count == ONE) : at_min;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_count  <= RV;
      gray_count <= RV_GRAY;
      tc         <= 1'b0;
    end else begin
      bin_count  <= nb;
      gray_count <= WIDTH'(bin2gray(32'(nb)));
      tc         <= ntc;
    end
  end

`ifdef GC_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic             ctrl_q;

  // Compares each registered Gray value with the one before it; jumps caused by load/clear are skipped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_gray <= RV_GRAY;
      ctrl_q    <= 1'b1;
      gc_err    <= 1'b0;
    end else begin
      prev_gray <= gray_count;
      ctrl_q    <= clear | load;
      if (clear) begin
        gc_err <= 1'b0;
      end else if (!ctrl_q && ($countones(prev_gray ^ gray_count) > 1)) begin
        gc_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iiitb_gc_updn.sv
// Bench for iiitb_gc_updn: three instances (wrap/8, saturate/8, wrap/4 with RESET_VAL=5) share stimulus.
module tb_iiitb_gc_updn;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_gray = 8'h00;

  logic [7:0] g_w, b_w, g_s, b_s;
  logic [3:0] g_r, b_r;
  logic       tc_w, tc_s, tc_r;
`ifdef GC_STEP_CHECK_EN
  logic       err_w, err_s, err_r;
`endif

  logic [7:0] go [3];
  logic [7:0] bo [3];
  logic       to [3];

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance.
  int m_bin [3];
  int m_tc  [3];
  int m_max [3] = '{255, 255, 15};
  int m_sat [3] = '{0, 1, 0};
  int m_rv  [3] = '{0, 0, 5};

  always #5 clk = ~clk;

  iiitb_gc_updn #(.WIDTH(8), .SATURATE(0), .RESET_VAL(0)) dut_w (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_gray(load_gray), .gray_count(g_w), .bin_count(b_w), .tc(tc_w)
`ifdef GC_STEP_CHECK_EN
    , .gc_err(err_w)
`endif
  );

  iiitb_gc_updn #(.WIDTH(8), .SATURATE(1), .RESET_VAL(0)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_gray(load_gray), .gray_count(g_s), .bin_count(b_s), .tc(tc_s)
`ifdef GC_STEP_CHECK_EN
    , .gc_err(err_s)
`endif
  );

  iiitb_gc_updn #(.WIDTH(4), .SATURATE(0), .RESET_VAL(5)) dut_r (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_gray(load_gray[3:0]), .gray_count(g_r), .bin_count(b_r), .tc(tc_r)
`ifdef GC_STEP_CHECK_EN
    , .gc_err(err_r)
`endif
  );

  assign go[0] = g_w;
  assign go[1] = g_s;
  assign go[2] = {4'h0, g_r};
  assign bo[0] = b_w;
  assign bo[1] = b_s;
  assign bo[2] = {4'h0, b_r};
  assign to[0] = tc_w;
  assign to[1] = tc_s;
  assign to[2] = tc_r;

  function automatic int m_g2b(input int g);
    int r = 0;
    for (int k = 0; k < 32; k++) r = r ^ (g >>> k);
    return r;
  endfunction

  function automatic logic [7:0] m_gray(input int b);
    return 8'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = m_rv[i];
      m_tc[i]  = 0;
    end
  endtask

  // Counter behaviour in plain integer arithmetic, one edge for every instance.
  task automatic model_edge();
    int nb;
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        m_bin[i] = m_rv[i]; m_tc[i] = 0;
      end else if (load) begin
        m_bin[i] = m_g2b(int'(load_gray) & m_max[i]); m_tc[i] = 0;
      end else if (!enable) begin
        m_tc[i] = 0;
      end else if (up_dn) begin
        if (m_sat[i] != 0 && m_bin[i] == m_max[i]) m_tc[i] = 0;
        else begin
          nb = (m_bin[i] + 1) % (m_max[i] + 1);
          m_tc[i] = (m_sat[i] != 0) ? int'(nb == m_max[i]) : int'(nb == 0);
          m_bin[i] = nb;
        end
      end else begin
        if (m_sat[i] != 0 && m_bin[i] == 0) m_tc[i] = 0;
        else begin
          nb = (m_bin[i] + m_max[i]) % (m_max[i] + 1);
          m_tc[i] = (m_sat[i] != 0) ? int'(nb == 0) : int'(nb == m_max[i]);
          m_bin[i] = nb;
        end
      end
    end
  endtask

  task automatic apply(input logic en, input logic ud, input logic clr, input logic ld,
                       input logic [7:0] lg);
    enable = en; up_dn = ud; clear = clr; load = ld; load_gray = lg;
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    #2;
    for (int e = 0; e < 2; e++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bo[i] !== 8'(m_rv[i]) || go[i] !== m_gray(m_rv[i]) || to[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold inst%0d got bin=%h gray=%h tc=%b want bin=%h gray=%h tc=0",
                   i, bo[i], go[i], to[i], 8'(m_rv[i]), m_gray(m_rv[i]));
        end
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_g [3] = '{8'h01, 8'h03, 8'h02};
    for (int e = 1; e <= 257; e++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      if (e <= 3) begin
        checks++;
        if (g_w !== exp_g[e-1]) begin
          errors++; $display("FAIL wrap_edge%0d got gray=%h want %h", e, g_w, exp_g[e-1]);
        end
      end
      if (e == 255) begin
        checks++;
        if (g_w !== 8'h80 || b_w !== 8'hFF) begin
          errors++; $display("FAIL wrap_max got gray=%h bin=%h want 80/ff", g_w, b_w);
        end
      end
      if (e == 256 || e == 257) begin
        checks++;
        if (g_w !== 8'h00 + 8'(e == 257) || tc_w !== (e == 256)) begin
          errors++; $display("FAIL wrap_tc edge%0d got gray=%h tc=%b", e, g_w, tc_w);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bo[i] !== 8'(m_bin[i]) || go[i] !== m_gray(m_bin[i]) || to[i] !== 1'(m_tc[i])) begin
          errors++;
          $display("FAIL wrap_model inst%0d edge%0d got bin=%h gray=%h tc=%b want bin=%h tc=%0d",
                   i, e, bo[i], go[i], to[i], 8'(m_bin[i]), m_tc[i]);
        end
      end
    end
  endtask

  task automatic test_down();
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (g_w !== 8'h80 || b_w !== 8'hFF || tc_w !== 1'b1) begin
      errors++; $display("FAIL down_first got gray=%h bin=%h tc=%b want 80/ff/1", g_w, b_w, tc_w);
    end
    checks++;
    if (b_s !== 8'h00 || tc_s !== 1'b0) begin
      errors++; $display("FAIL down_sat_floor got bin=%h tc=%b want 00/0", b_s, tc_s);
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (g_w !== 8'h81 || b_w !== 8'hFE || tc_w !== 1'b0) begin
      errors++; $display("FAIL down_second got gray=%h bin=%h tc=%b want 81/fe/0", g_w, b_w, tc_w);
    end
  endtask

  task automatic test_load();
    apply(1'b1, 1'b1, 1'b0, 1'b1, 8'hC0);
    checks++;
    if (b_w !== 8'h80 || g_w !== 8'hC0 || tc_w !== 1'b0) begin
      errors++; $display("FAIL load_c0 got bin=%h gray=%h tc=%b want 80/c0/0", b_w, g_w, tc_w);
    end
    apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (g_w !== 8'hC1) begin
      errors++; $display("FAIL load_then_up got gray=%h want c1", g_w);
    end
  endtask

  task automatic test_saturate();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 8'h81);
    checks++;
    if (b_s !== 8'hFE) begin
      errors++; $display("FAIL sat_load got bin=%h want fe", b_s);
    end
    apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (b_s !== 8'hFF || g_s !== 8'h80 || tc_s !== 1'b1) begin
      errors++; $display("FAIL sat_reach got bin=%h gray=%h tc=%b want ff/80/1", b_s, g_s, tc_s);
    end
    for (int e = 0; e < 2; e++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if (b_s !== 8'hFF || tc_s !== 1'b0) begin
        errors++; $display("FAIL sat_hold got bin=%h tc=%b want ff/0", b_s, tc_s);
      end
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (b_s !== 8'hFE || tc_s !== 1'b0) begin
      errors++; $display("FAIL sat_reverse got bin=%h tc=%b want fe/0", b_s, tc_s);
    end
  endtask

  task automatic test_async_reset_clear();
    apply(1'b0, 1'b1, 1'b0, 1'b1, 8'h2C);
    checks++;
    if (b_w !== 8'h37) begin
      errors++; $display("FAIL mid_load got bin=%h want 37", b_w);
    end
    #3 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (b_w !== 8'h00 || g_w !== 8'h00 || b_r !== 4'd5 || g_r !== 4'd7) begin
      errors++; $display("FAIL async_reset got w=%h/%h r=%h/%h want 00/00 5/7", b_w, g_w, b_r, g_r);
    end
    #2 reset = 1'b1;
    for (int e = 0; e < 3; e++) apply(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    checks++;
    if (b_r !== 4'd5 || g_r !== 4'd7 || b_w !== 8'h00 || tc_r !== 1'b0) begin
      errors++; $display("FAIL clear got r=%h/%h w=%h tc=%b want 5/7 00 0", b_r, g_r, b_w, tc_r);
    end
  endtask

  task automatic test_random();
    logic [7:0] picks [4] = '{8'h00, 8'h80, 8'h81, 8'h01};
    logic [7:0] lg;
    for (int n = 0; n < 700; n++) begin
      lg = ($urandom_range(0, 1) != 0) ? picks[$urandom_range(0, 3)] : 8'($urandom);
      apply($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0,
            $urandom_range(0, 25) == 0, lg);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bo[i] !== 8'(m_bin[i]) || go[i] !== m_gray(m_bin[i]) || to[i] !== 1'(m_tc[i])) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d got bin=%h gray=%h tc=%b want bin=%h tc=%0d",
                   i, n, bo[i], go[i], to[i], 8'(m_bin[i]), m_tc[i]);
        end
      end
`ifdef GC_STEP_CHECK_EN
      checks++;
      if ({err_w, err_s, err_r} !== 3'b000) begin
        errors++; $display("FAIL random_gc_err cyc%0d got %b%b%b want 000", n, err_w, err_s, err_r);
      end
`endif
    end
  endtask

`ifdef GC_STEP_CHECK_EN
  task automatic test_step_check();
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    force dut_w.gray_count = g_w ^ 8'h03;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    release dut_w.gray_count;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (err_w !== 1'b1) begin
      errors++; $display("FAIL gc_err_set got %b want 1", err_w);
    end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if (err_w !== 1'b0) begin
      errors++; $display("FAIL gc_err_clear got %b want 0", err_w);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap_up();
    test_down();
    test_load();
    test_saturate();
    test_async_reset_clear();
    test_random();
`ifdef GC_STEP_CHECK_EN
    test_step_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
